// File: rtl/alarm_unit.sv
// Alarm stage: BCD alarm time register, match-edge detector, ring/snooze FSM and gated tone.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_unit #(
    parameter int TONE_DIV    = 25000,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic [3:0] m0,
    input  logic [3:0] m1,
    input  logic [3:0] h0,
    input  logic [3:0] h1,
    input  logic       arm,
    input  logic       set_en,
    input  logic       set_sel,
    input  logic       set_inc,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] al_m0,
    output logic [3:0] al_m1,
    output logic [3:0] al_h0,
    output logic [3:0] al_h1,
    output logic       ringing,
    output logic       speaker
);

    localparam int TW = $clog2(TONE_DIV + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t          state, state_n;
    logic            match_now, match_p0, match_p1, fire;
    logic            ring_expire, snooze_act, snooze_expire;
    logic            enter_ring, stay_ring;
    logic [RW-1:0]   ring_cnt;
    logic [TW-1:0]   tone_cnt;
    logic            tone, gate;

    // Minutes wrap 59 -> 00 without touching the hours.
    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (u == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (t == 4'd5) ? 4'd0 : t + 4'd1;
        end else begin
            r = {t, u + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] hr_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t == 4'd2 && u == 4'd3)
            r = 8'h00;
        else if (u == 4'd9)
            r = {t + 4'd1, 4'd0};
        else
            r = {t, u + 4'd1};
        return r;
    endfunction

    assign match_now = (h1 == al_h1) && (h0 == al_h0) && (m1 == al_m1) && (m0 == al_m0) &&
                       (s1 == 4'd0) && (s0 == 4'd0) && arm && !set_en;
    assign fire        = match_p0 && !match_p1;
    assign ring_expire = tick && (ring_cnt == RW'(RING_SECS - 1));

`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    logic [SW-1:0] snooze_cnt;

    assign snooze_act    = (state == RINGING) && snooze;
    assign snooze_expire = (state == SNOOZE) && tick && (snooze_cnt == SW'(SNOOZE_SECS - 1));

    always_ff @(posedge clk) begin
        if (!clr)
            snooze_cnt <= '0;
        else if (state != SNOOZE)
            snooze_cnt <= '0;
        else if (tick)
            snooze_cnt <= snooze_cnt + SW'(1);
    end
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
    assign snooze_act    = 1'b0;
    assign snooze_expire = 1'b0;
`endif

    // Priority: arm=0 > stop > snooze > counter expiry.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (arm && fire) state_n = RINGING;
            RINGING: begin
                if (!arm || stop)     state_n = IDLE;
                else if (snooze_act)  state_n = SNOOZE;
                else if (ring_expire) state_n = IDLE;
            end
            SNOOZE: begin
                if (!arm || stop)       state_n = IDLE;
                else if (snooze_expire) state_n = RINGING;
            end
            default: state_n = IDLE;
        endcase
    end

    assign enter_ring = (state != RINGING) && (state_n == RINGING);
    assign stay_ring  = (state == RINGING) && (state_n == RINGING);

    always_ff @(posedge clk) begin
        if (!clr) begin
            al_h1    <= 4'd0;
            al_h0    <= 4'd7;
            al_m1    <= 4'd0;
            al_m0    <= 4'd0;
            match_p0 <= 1'b0;
            match_p1 <= 1'b0;
            state    <= IDLE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
            gate     <= 1'b0;
        end else begin
            if (set_en && set_inc) begin
                if (!set_sel) {al_m1, al_m0} <= min_inc(al_m1, al_m0);
                else          {al_h1, al_h0} <= hr_inc(al_h1, al_h0);
            end
            // ---- stage p0: sample match; stage p1: previous match for edge detect ----
            match_p0 <= match_now;
            match_p1 <= match_p0;
            state    <= state_n;
            ringing  <= (state_n == RINGING);
            if (stay_ring) begin
                if (tick) begin
                    ring_cnt <= ring_cnt + RW'(1);
                    gate     <= ~gate;
                end
                if (tone_cnt == TW'(TONE_DIV - 1)) begin
                    tone_cnt <= '0;
                    tone     <= ~tone;
                end else begin
                    tone_cnt <= tone_cnt + TW'(1);
                end
            end else begin
                ring_cnt <= '0;
                tone_cnt <= '0;
                tone     <= 1'b0;
                gate     <= enter_ring;
            end
        end
    end

    assign speaker = tone && gate && ringing;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed-vector bench for alarm_unit with a short tone divider and snooze period.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       clr, tick, arm, set_en, set_sel, set_inc, stop, snooze;
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic [3:0] al_m0, al_m1, al_h0, al_h1;
    logic       ringing, speaker;
    int         checks = 0;
    int         errors = 0;
    logic       acc;

    always #5 clk = ~clk;

    alarm_unit #(.TONE_DIV(4), .RING_SECS(60), .SNOOZE_SECS(5)) dut (
        .clk(clk), .clr(clr), .tick(tick),
        .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h0(h0), .h1(h1),
        .arm(arm), .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
        .stop(stop), .snooze(snooze),
        .al_m0(al_m0), .al_m1(al_m1), .al_h0(al_h0), .al_h1(al_h1),
        .ringing(ringing), .speaker(speaker)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        h1 = a; h0 = b; m1 = c; m0 = d; s1 = e; s0 = f;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            set_inc = 1'b1;
            step();
            set_inc = 1'b0;
            step();
        end
    endtask

    // Drive the time through 00:00:59 -> 00:01:00 and wait the registered latency.
    task automatic hit_0001();
        set_time(0, 0, 0, 0, 5, 9);
        step();
        set_time(0, 0, 0, 1, 0, 0);
        step();
        step();
    endtask

    initial begin
        clr = 1'b0; tick = 1'b0; arm = 1'b0; set_en = 1'b0; set_sel = 1'b0;
        set_inc = 1'b0; stop = 1'b0; snooze = 1'b0;
        set_time(0, 0, 0, 0, 0, 0);
        step();
        step();
        clr = 1'b1;
        check("reset_alarm", {al_h1, al_h0, al_m1, al_m0}, 32'h0700);
        check("reset_ringing", ringing, 0);
        check("reset_speaker", speaker, 0);

        arm = 1'b1;
        set_time(0, 6, 5, 9, 5, 9);
        step();
        set_time(0, 7, 0, 0, 0, 0);
        step();
        check("match_latency", ringing, 0);
        step();
        check("ring_entry", ringing, 1);
        check("spk_entry", speaker, 0);
        for (int i = 0; i < 3; i++) step();
        check("spk_before_div", speaker, 0);
        step();
        check("spk_first_high", speaker, 1);
        for (int i = 0; i < 3; i++) step();
        check("spk_high_hold", speaker, 1);
        step();
        check("spk_low_half", speaker, 0);

        do_tick();
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            acc |= speaker;
            step();
        end
        check("spk_gate_off", acc, 0);
        do_tick();
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            acc |= speaker;
        end
        check("spk_gate_on", acc, 1);
        for (int t = 3; t <= 59; t++) begin
            do_tick();
            step();
        end
        check("ring_tick59", ringing, 1);
        do_tick();
        check("ring_timeout", ringing, 0);
        check("spk_timeout", speaker, 0);
        for (int t = 0; t < 3; t++) begin
            do_tick();
            step();
        end
        check("no_retrigger", ringing, 0);

        set_en = 1'b1;
        set_sel = 1'b0;
        pulse_inc(61);
        check("min_wrap", {al_h1, al_h0, al_m1, al_m0}, 32'h0701);
        set_sel = 1'b1;
        pulse_inc(17);
        check("hour_wrap", {al_h1, al_h0, al_m1, al_m0}, 32'h0001);
        set_en = 1'b0;
        pulse_inc(1);
        check("inc_ignored", {al_h1, al_h0, al_m1, al_m0}, 32'h0001);

        hit_0001();
        check("ring_0001", ringing, 1);
        stop = 1'b1;
        snooze = 1'b1;
        step();
        stop = 1'b0;
        snooze = 1'b0;
        check("stop_snooze_ring", ringing, 0);
        check("stop_snooze_spk", speaker, 0);

        hit_0001();
        check("ring_again", ringing, 1);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check("snooze_enter", ringing, 0);
        check("snooze_spk", speaker, 0);
        for (int t = 0; t < 4; t++) begin
            do_tick();
            step();
        end
        check("snooze_tick4", ringing, 0);
        do_tick();
        check("snooze_expire", ringing, 1);
`else
        check("snooze_ignored", ringing, 1);
`endif
        arm = 1'b0;
        step();
        check("disarm", ringing, 0);

        arm = 1'b1;
        set_en = 1'b1;
        hit_0001();
        step();
        check("set_en_blocks", ringing, 0);
        set_time(0, 0, 0, 2, 0, 0);
        step();
        set_en = 1'b0;
        step();
        step();
        check("set_en_release", ringing, 0);

        hit_0001();
        check("ring_pre_clr", ringing, 1);
        clr = 1'b0;
        stop = 1'b1;
        step();
        clr = 1'b1;
        stop = 1'b0;
        check("clr_ringing", ringing, 0);
        check("clr_speaker", speaker, 0);
        check("clr_alarm", {al_h1, al_h0, al_m1, al_m0}, 32'h0700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage that consumes the BCD time digits produced by the clock counters (s0/s1, m0/m1, h0/h1) and drives the speaker and alarm-status outputs. It holds a user-settable alarm time (HH:MM, BCD) and compares it against running time. On a match it rings a gated tone, with stop, optional snooze and automatic time-out. It sits between the counter chain and the speaker/display path, alongside the hourly chime.

## Interface
- TONE_DIV, 25000: clk cycles per speaker half-period while tone is on.
- RING_SECS, 60: ticks of ringing before automatic return to IDLE.
- SNOOZE_SECS, 300: ticks spent in SNOOZE before ringing again.
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, synchronous, active-low.
- tick  in  1  1 Hz strobe, exactly one clk cycle wide.
- s0, s1, m0, m1, h0, h1  in  4 each  running time, BCD (units, tens).
- arm  in  1  level; 1 = alarm enabled.
- set_en  in  1  level; 1 = alarm-set mode.
- set_sel  in  1  0 = adjust minutes, 1 = adjust hours.
- set_inc  in  1  single-cycle increment pulse.
- stop  in  1  single-cycle pulse; silence alarm.
- snooze  in  1  single-cycle pulse; defer alarm.
- al_m0, al_m1, al_h0, al_h1  out  4 each  alarm time, BCD, for display.
- ringing  out  1  1 while in RINGING.
- speaker  out  1  gated tone output.

## Operation
- Reset (clr=0 at an edge): alarm = 07:00 (al_h1=0, al_h0=7, al_m1=0, al_m0=0), state IDLE, ringing=0, speaker=0, all counters 0.
- Alarm set: a set_inc pulse with set_en=1 increments the minutes (set_sel=0) or the hours (set_sel=1) in BCD.
  - Minutes wrap 59→00 with no carry into hours.
  - Hours wrap 23→00.
  - set_inc is ignored when set_en=0.
- Match condition: h1:h0:m1:m0 equals the alarm, s1=0, s0=0, arm=1 and set_en=0. Only the rising edge of the match (registered previous-cycle match flag) fires.
- States:
  - IDLE → RINGING on match edge; ring counter cleared.
  - RINGING → IDLE on stop, or when the ring counter reaches RING_SECS ticks.
  - RINGING → SNOOZE on snooze; snooze counter cleared.
  - SNOOZE → RINGING when the snooze counter reaches SNOOZE_SECS ticks; ring counter cleared.
  - SNOOZE → IDLE on stop.
  - Any state → IDLE when arm=0.
- Priority in a single cycle: arm=0 > stop > snooze > counter expiry.
- A match edge in RINGING or SNOOZE is ignored.
- Speaker: a tone divider toggles every TONE_DIV cycles. A beep gate toggles on each tick while RINGING, giving 1 s on / 1 s off, and starts on at RINGING entry. speaker = tone & gate & (state==RINGING). Otherwise speaker is 0 and the divider and gate are held at 0.
- Alarm-set edits during RINGING/SNOOZE take effect immediately and do not change state.
- Time digits are compared literally; non-BCD inputs simply never match.

## Timing
- Match edge seen at edge N → ringing=1 after edge N+1 (one-cycle registered latency). The first speaker high is TONE_DIV cycles after RINGING entry.
- stop/snooze sampled at edge N → state and ringing change after edge N; speaker is 0 from the same edge.
- Ring time-out: ringing falls on the edge where the RING_SECS-th tick since entry is sampled.
- Snooze expiry: RINGING is re-entered on the edge where the SNOOZE_SECS-th tick is sampled.
- Alarm digits update on the edge that samples set_inc.
- clr low mid-ring forces reset values on the next edge regardless of other inputs.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state, snooze counter and the snooze input are active as described.
- Not defined: the snooze input is ignored and no snooze counter is instantiated. RINGING exits only via stop, time-out or arm=0.

## Test plan
- Reset then hold arm=1 with time stepped 06:59:59 → 07:00:00: ringing=1 one cycle later. speaker toggles with period 2·TONE_DIV during gate-on seconds and is 0 during gate-off seconds.
- Ringing, no input, 60 ticks (RING_SECS=60): ringing=0 on the 60th tick edge. Time held at 07:00:00 does not retrigger.
- set_en=1, set_sel=0, 61 set_inc pulses from 07:00 → alarm 07:01 (wrap, no hour carry). With set_sel=1, 17 pulses → 00:01.
- Ringing, stop and snooze asserted on the same cycle → IDLE, ringing=0, speaker=0 next edge.
- (ALARM_SNOOZE_EN) snooze during ringing, SNOOZE_SECS=5 → ringing=0 for 5 ticks, then 1 again. Then arm=0 → IDLE at next edge.
- set_en=1 while time passes the alarm minute → no ring. clr=0 during RINGING → reset values, alarm 07:00.
